// File: rtl/axi_light_master_arb.sv
// Round-robin arbiter merging N_MASTERS AXI-light master ports onto one, one transaction in flight.
// Optional response watchdog with timeout_err output: define ARB_TIMEOUT_EN.
module axi_light_master_arb #(
  parameter int N_MASTERS      = 2,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int GW            = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1,
  localparam int STRB_W        = DATA_W / 8
) (
  input  logic                          clk,
  input  logic                          res_n,
  input  logic [N_MASTERS-1:0]          s_awvalid,
  output logic [N_MASTERS-1:0]          s_awready,
  input  logic [N_MASTERS*ADDR_W-1:0]   s_awaddr,
  input  logic [N_MASTERS-1:0]          s_wvalid,
  output logic [N_MASTERS-1:0]          s_wready,
  input  logic [N_MASTERS*DATA_W-1:0]   s_wdata,
  input  logic [N_MASTERS*STRB_W-1:0]   s_wstrb,
  output logic [N_MASTERS-1:0]          s_bvalid,
  input  logic [N_MASTERS-1:0]          s_bready,
  input  logic [N_MASTERS-1:0]          s_arvalid,
  output logic [N_MASTERS-1:0]          s_arready,
  input  logic [N_MASTERS*ADDR_W-1:0]   s_araddr,
  output logic [N_MASTERS-1:0]          s_rvalid,
  input  logic [N_MASTERS-1:0]          s_rready,
  output logic [DATA_W-1:0]             s_rdata,
  output logic                          m_awvalid,
  input  logic                          m_awready,
  output logic [ADDR_W-1:0]             m_awaddr,
  output logic                          m_wvalid,
  input  logic                          m_wready,
  output logic [DATA_W-1:0]             m_wdata,
  output logic [STRB_W-1:0]             m_wstrb,
  input  logic                          m_bvalid,
  output logic                          m_bready,
  output logic                          m_arvalid,
  input  logic                          m_arready,
  output logic [ADDR_W-1:0]             m_araddr,
  input  logic                          m_rvalid,
  output logic                          m_rready,
  input  logic [DATA_W-1:0]             m_rdata,
  output logic [GW-1:0]                 grant
`ifdef ARB_TIMEOUT_EN
  ,
  output logic                          timeout_err
`endif
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR      = 3'd1;
  localparam logic [2:0] S_WR_RESP = 3'd2;
  localparam logic [2:0] S_RD      = 3'd3;
  localparam logic [2:0] S_RD_RESP = 3'd4;

  logic [2:0]           state;
  logic [GW-1:0]        ptr;
  logic                 aw_done, w_done;
  logic [N_MASTERS-1:0] wr_req, req, grant_oh;
  logic                 found;
  logic [GW-1:0]        sel, next_ptr;
  logic [GW:0]          cand;
  logic                 aw_fire, w_fire, aw_ok, w_ok, ar_fire, b_fire, r_fire;
  logic                 to_hit;

  assign wr_req = s_awvalid & s_wvalid;
  assign req    = wr_req | s_arvalid;

  // First requester at or above ptr, wrapping; cand never exceeds 2*N-2 so one subtract suffices.
  always_comb begin
    found = 1'b0;
    sel   = ptr;
    cand  = '0;
    for (int k = 0; k < N_MASTERS; k++) begin
      cand = {1'b0, ptr} + (GW+1)'(k);
      if (cand >= (GW+1)'(N_MASTERS)) cand = cand - (GW+1)'(N_MASTERS);
      if (!found && req[cand[GW-1:0]]) begin
        found = 1'b1;
        sel   = cand[GW-1:0];
      end
    end
  end

  assign next_ptr = (grant == GW'(N_MASTERS - 1)) ? '0 : grant + GW'(1);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    grant_oh        = '0;
    grant_oh[grant] = 1'b1;
    s_awready = '0;
    s_wready  = '0;
    s_bvalid  = '0;
    s_arready = '0;
    s_rvalid  = '0;
    m_awvalid = 1'b0;
    m_wvalid  = 1'b0;
    m_bready  = 1'b0;
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    m_awaddr  = s_awaddr[int'(grant)*ADDR_W +: ADDR_W];
    m_wdata   = s_wdata[int'(grant)*DATA_W +: DATA_W];
    m_wstrb   = s_wstrb[int'(grant)*STRB_W +: STRB_W];
    m_araddr  = s_araddr[int'(grant)*ADDR_W +: ADDR_W];
    s_rdata   = m_rdata;
    case (state)
      S_WR: begin
        m_awvalid = s_awvalid[grant] & ~aw_done;
        m_wvalid  = s_wvalid[grant] & ~w_done;
        s_awready = grant_oh & {N_MASTERS{m_awready & ~aw_done}};
        s_wready  = grant_oh & {N_MASTERS{m_wready & ~w_done}};
      end
      S_WR_RESP: begin
        if (to_hit) begin
          s_bvalid = grant_oh;
        end else begin
          s_bvalid = grant_oh & {N_MASTERS{m_bvalid}};
          m_bready = s_bready[grant];
        end
      end
      S_RD: begin
        m_arvalid = s_arvalid[grant];
        s_arready = grant_oh & {N_MASTERS{m_arready}};
      end
      S_RD_RESP: begin
        if (to_hit) begin
          s_rvalid = grant_oh;
          s_rdata  = DATA_W'(32'hDEAD_BEEF);
        end else begin
          s_rvalid = grant_oh & {N_MASTERS{m_rvalid}};
          m_rready = s_rready[grant];
        end
      end
      default: ;
    endcase
  end

  assign aw_fire = m_awvalid & m_awready;
  assign w_fire  = m_wvalid & m_wready;
  assign aw_ok   = aw_done | aw_fire;
  assign w_ok    = w_done | w_fire;
  assign ar_fire = m_arvalid & m_arready;
  // Master-side handshakes cover both the forwarded response and a watchdog-generated one.
  assign b_fire  = |(s_bvalid & s_bready);
  assign r_fire  = |(s_rvalid & s_rready);

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state   <= S_IDLE;
      ptr     <= '0;
      grant   <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            grant <= sel;
            state <= wr_req[sel] ? S_WR : S_RD;
          end
        end
        S_WR: begin
          if (aw_ok && w_ok) begin
            state   <= S_WR_RESP;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end else begin
            aw_done <= aw_ok;
            w_done  <= w_ok;
          end
        end
        S_WR_RESP: begin
          if (b_fire) begin
            state <= S_IDLE;
            ptr   <= next_ptr;
          end
        end
        S_RD: begin
          if (ar_fire) state <= S_RD_RESP;
        end
        S_RD_RESP: begin
          if (r_fire) begin
            state <= S_IDLE;
            ptr   <= next_ptr;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt;
  logic            in_resp;

  assign in_resp = (state == S_WR_RESP) || (state == S_RD_RESP);
  assign to_hit  = in_resp && (to_cnt == TO_W'(TIMEOUT_CYCLES));

  // Counts cycles spent waiting for the slave response; saturates at the limit until the handshake.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (in_resp && !b_fire && !r_fire) begin
        if (!to_hit) to_cnt <= to_cnt + TO_W'(1);
      end else begin
        to_cnt <= '0;
      end
      if (to_hit) timeout_err <= 1'b1;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

endmodule

// File: tb/tb_axi_light_master_arb.sv
// Scoreboard bench for axi_light_master_arb (N_MASTERS=4): stimulus pushes expectations, a monitor pops them.
// The watchdog scenario is compiled in only when ARB_TIMEOUT_EN is defined.
module tb_axi_light_master_arb;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int GW = 2;

  logic clk = 1'b0;
  logic res_n;
  always #5 clk = ~clk;

  logic [N-1:0]    s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [N-1:0]    s_arvalid, s_arready, s_rvalid, s_rready;
  logic [N*AW-1:0] s_awaddr, s_araddr;
  logic [N*DW-1:0] s_wdata;
  logic [N*SW-1:0] s_wstrb;
  logic [DW-1:0]   s_rdata;
  logic            m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic            m_arvalid, m_arready, m_rvalid, m_rready;
  logic [AW-1:0]   m_awaddr, m_araddr;
  logic [DW-1:0]   m_wdata, m_rdata;
  logic [SW-1:0]   m_wstrb;
  logic [GW-1:0]   grant;
`ifdef ARB_TIMEOUT_EN
  logic            timeout_err;
`endif

  axi_light_master_arb #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .res_n(res_n),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
    .grant(grant)
`ifdef ARB_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  wire [24:0] all_vr = {s_awready, s_wready, s_bvalid, s_arready, s_rvalid,
                        m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready};

  typedef struct {
    int          m;
    logic [31:0] v;
    logic [3:0]  s;
  } exp_t;

  exp_t exp_aw[$], exp_w[$], exp_b[$], exp_ar[$], exp_r[$];
  int checks   = 0;
  int failures = 0;

  // Slave model state
  logic        got_aw, got_w, got_ar, r_hold;
  logic [31:0] rd_val;
  int          aw_wait, w_wait, aw_delay, w_delay;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [N-1:0] oh(input int m);
    oh    = '0;
    oh[m] = 1'b1;
  endfunction

  // Monitor: pops expectations whenever the DUT presents a handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (res_n) begin
        check("route", 64'((s_awready | s_wready | s_arready | s_bvalid | s_rvalid) & ~oh(int'(grant))), 64'd0);
        if (m_awvalid && m_awready) begin
          if (exp_aw.size() == 0) check("aw_unexpected", 64'd1, 64'd0);
          else begin
            e = exp_aw.pop_front();
            check("aw_grant", 64'(grant), 64'(e.m));
            check("aw_addr", 64'(m_awaddr), 64'(e.v));
          end
        end
        if (m_wvalid && m_wready) begin
          if (exp_w.size() == 0) check("w_unexpected", 64'd1, 64'd0);
          else begin
            e = exp_w.pop_front();
            check("w_grant", 64'(grant), 64'(e.m));
            check("w_data", 64'(m_wdata), 64'(e.v));
            check("w_strb", 64'(m_wstrb), 64'(e.s));
          end
        end
        if (m_arvalid && m_arready) begin
          if (exp_ar.size() == 0) check("ar_unexpected", 64'd1, 64'd0);
          else begin
            e = exp_ar.pop_front();
            check("ar_grant", 64'(grant), 64'(e.m));
            check("ar_addr", 64'(m_araddr), 64'(e.v));
          end
        end
        if (|(s_bvalid & s_bready)) begin
          if (exp_b.size() == 0) check("b_unexpected", 64'd1, 64'd0);
          else begin
            e = exp_b.pop_front();
            check("b_route", 64'(s_bvalid), 64'(oh(e.m)));
          end
        end
        if (|(s_rvalid & s_rready)) begin
          if (exp_r.size() == 0) check("r_unexpected", 64'd1, 64'd0);
          else begin
            e = exp_r.pop_front();
            check("r_route", 64'(s_rvalid), 64'(oh(e.m)));
            check("r_data", 64'(s_rdata), 64'(e.v));
          end
        end
      end
    end
  end

  // One clock of master and slave behaviour: sample at negedge, react 1 time unit after posedge.
  task automatic step();
    logic [N-1:0] aw_hs, w_hs, ar_hs;
    logic         maw, mw, mar, mb, mr;
    logic [31:0]  ar_addr_s;
    @(negedge clk);
    aw_hs = s_awvalid & s_awready;
    w_hs  = s_wvalid & s_wready;
    ar_hs = s_arvalid & s_arready;
    maw = m_awvalid & m_awready;
    mw  = m_wvalid & m_wready;
    mar = m_arvalid & m_arready;
    mb  = m_bvalid & m_bready;
    mr  = m_rvalid & m_rready;
    ar_addr_s = m_araddr;
    @(posedge clk);
    #1;
    if (!res_n) begin
      got_aw = 1'b0; got_w = 1'b0; got_ar = 1'b0;
      m_bvalid = 1'b0; m_rvalid = 1'b0;
      m_awready = 1'b0; m_wready = 1'b0; m_arready = 1'b0;
      aw_wait = 0; w_wait = 0;
    end else begin
      if (maw) got_aw = 1'b1;
      if (mw) got_w = 1'b1;
      if (mar) begin
        got_ar = 1'b1;
        rd_val = {16'hA5A5, ar_addr_s[15:0]};
      end
      if (mb) m_bvalid = 1'b0;
      if (mr) m_rvalid = 1'b0;
      if (got_aw && got_w && !m_bvalid) begin
        m_bvalid = 1'b1; got_aw = 1'b0; got_w = 1'b0;
      end
      if (got_ar && !m_rvalid && !r_hold) begin
        m_rvalid = 1'b1; m_rdata = rd_val; got_ar = 1'b0;
      end
      if (m_awvalid) begin m_awready = (aw_wait >= aw_delay); aw_wait++; end
      else begin m_awready = 1'b0; aw_wait = 0; end
      if (m_wvalid) begin m_wready = (w_wait >= w_delay); w_wait++; end
      else begin m_wready = 1'b0; w_wait = 0; end
      m_arready = m_arvalid;
    end
    s_awvalid = s_awvalid & ~aw_hs;
    s_wvalid  = s_wvalid & ~w_hs;
    s_arvalid = s_arvalid & ~ar_hs;
  endtask

  task automatic set_write(input int m, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    s_awvalid[m] = 1'b1;
    s_wvalid[m]  = 1'b1;
    s_awaddr[m*AW +: AW] = addr;
    s_wdata[m*DW +: DW]  = data;
    s_wstrb[m*SW +: SW]  = strb;
    exp_aw.push_back('{m: m, v: addr, s: 4'h0});
    exp_w.push_back('{m: m, v: data, s: strb});
    exp_b.push_back('{m: m, v: 32'h0, s: 4'h0});
  endtask

  task automatic set_read(input int m, input logic [31:0] addr, input bit has_r, input logic [31:0] rexp);
    s_arvalid[m] = 1'b1;
    s_araddr[m*AW +: AW] = addr;
    exp_ar.push_back('{m: m, v: addr, s: 4'h0});
    if (has_r) exp_r.push_back('{m: m, v: rexp, s: 4'h0});
  endtask

  function automatic int pending();
    return exp_aw.size() + exp_w.size() + exp_b.size() + exp_ar.size() + exp_r.size();
  endfunction

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (pending() != 0 || (s_awvalid | s_wvalid | s_arvalid) != '0) begin
      if (n == budget) begin
        check({name, "_budget"}, 64'(pending()), 64'd0);
        exp_aw.delete(); exp_w.delete(); exp_b.delete(); exp_ar.delete(); exp_r.delete();
        s_awvalid = '0; s_wvalid = '0; s_arvalid = '0;
        break;
      end
      step();
      n++;
    end
    step();
  endtask

  initial begin
    int n;
    res_n = 1'b0;
    s_awvalid = '0; s_wvalid = '0; s_arvalid = '0;
    s_awaddr = '0; s_araddr = '0; s_wdata = '0; s_wstrb = '0;
    s_bready = '1; s_rready = '1;
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
    got_aw = 1'b0; got_w = 1'b0; got_ar = 1'b0; r_hold = 1'b0; rd_val = '0;
    aw_wait = 0; w_wait = 0; aw_delay = 0; w_delay = 0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_outputs", 64'(all_vr), 64'd0);
    check("rst_grant", 64'(grant), 64'd0);
    res_n = 1'b1;
    step();

    // Two rounds of all four masters reading together: grants 0,1,2,3 each round.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < N; i++) begin
        logic [31:0] a;
        a = 32'h1000 + 32'(r * 256) + 32'(i * 16);
        set_read(i, a, 1'b1, 32'hA5A5_0000 | a);
      end
      drain("rr", 100);
    end

    // Single write from master 0 with one-cycle arbitration latency.
    set_write(0, 32'h0000_0100, 32'h1122_3344, 4'hF);
    #1;
    check("lat_idle_awvalid", 64'(m_awvalid), 64'd0);
    step();
    check("lat_awvalid", 64'(m_awvalid), 64'd1);
    check("lat_awaddr", 64'(m_awaddr), 64'h100);
    check("lat_grant", 64'(grant), 64'd0);
    drain("wr0", 50);

    // Master 1 requests write and read together: write goes first.
    set_write(1, 32'h0000_0204, 32'hCAFE_0001, 4'h3);
    set_read(1, 32'h0000_0208, 1'b1, 32'hA5A5_0208);
    step();
    check("wr_first_aw", 64'(m_awvalid), 64'd1);
    check("wr_first_ar", 64'(m_arvalid), 64'd0);
    check("wr_first_grant", 64'(grant), 64'd1);
    drain("wr_rd1", 60);

    // W accepted three cycles before AW, with master 3 reading in the background.
    aw_delay = 3;
    set_write(2, 32'h0000_0300, 32'h5566_7788, 4'hC);
    set_read(3, 32'h0000_0310, 1'b1, 32'hA5A5_0310);
    drain("w_before_aw", 80);
    aw_delay = 0;

    // Master 1 drops its read request before ever being granted.
    set_write(0, 32'h0000_0400, 32'h0BAD_F00D, 4'h1);
    s_arvalid[1] = 1'b1;
    s_araddr[1*AW +: AW] = 32'h0000_0410;
    step();
    check("ign_grant", 64'(grant), 64'd0);
    s_arvalid[1] = 1'b0;
    drain("ignore", 50);

    // Reset while waiting for R: outputs drop immediately and ptr returns to 0.
    r_hold = 1'b1;
    set_read(3, 32'h0000_3300, 1'b0, 32'h0);
    n = 0;
    while (exp_ar.size() != 0 && n < 20) begin step(); n++; end
    check("rst_mid_ar_done", 64'(exp_ar.size()), 64'd0);
    step();
    step();
    res_n = 1'b0;
    #1;
    check("rst_mid_outputs", 64'(all_vr), 64'd0);
    check("rst_mid_grant", 64'(grant), 64'd0);
    step();
    step();
    r_hold = 1'b0;
    res_n  = 1'b1;
    set_read(0, 32'h0000_0500, 1'b1, 32'hA5A5_0500);
    set_read(2, 32'h0000_0520, 1'b1, 32'hA5A5_0520);
    step();
    check("rst_ptr_grant", 64'(grant), 64'd0);
    drain("post_rst", 60);

`ifdef ARB_TIMEOUT_EN
    // Slave never answers R: the watchdog answers after 16 cycles with 0xDEADBEEF.
    r_hold = 1'b1;
    set_read(1, 32'h0000_4400, 1'b1, 32'hDEAD_BEEF);
    n = 0;
    while (exp_ar.size() != 0 && n < 20) begin step(); n++; end
    n = 0;
    while (s_rvalid == '0 && n < 40) begin step(); n++; end
    check("to_latency", 64'(n), 64'd16);
    check("to_rready", 64'(m_rready), 64'd0);
    drain("to", 20);
    check("to_err_set", 64'(timeout_err), 64'd1);
    got_ar = 1'b0;
    r_hold = 1'b0;
    repeat (5) step();
    check("to_err_held", 64'(timeout_err), 64'd1);
    res_n = 1'b0;
    #1;
    check("to_err_cleared", 64'(timeout_err), 64'd0);
    step();
    res_n = 1'b1;
    step();
`endif

    check("queues_empty", 64'(pending()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
